// File: rtl/pc_seq_if.sv
// rtl/pc_seq_if.sv - fetch-stage control bundle between hazard/branch logic and the PC sequencer
interface pc_seq_if #(
  parameter int PC_W = 16
);
  logic            run_en;
  logic            stall_req;
  logic            br_taken;
  logic [PC_W-1:0] br_target;
  logic            jmp;
  logic [PC_W-1:0] jmp_target;
  logic            halt_req;
  logic            resume;
  logic [PC_W-1:0] pc_out;
  logic            pc_en;
  logic            if_flush;
  logic            fetch_valid;
  logic [2:0]      state;

  // Pipeline control side: raises events, observes the fetch address.
  modport master (
    output run_en, stall_req, br_taken, br_target, jmp, jmp_target, halt_req, resume,
    input  pc_out, pc_en, if_flush, fetch_valid, state
  );

  // Sequencer side: consumes events, owns the program counter.
  modport slave (
    input  run_en, stall_req, br_taken, br_target, jmp, jmp_target, halt_req, resume,
    output pc_out, pc_en, if_flush, fetch_valid, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC next-address FSM; optional counters under PC_STATS_EN
module pc_sequencer #(
  parameter int                 PC_W      = 16,
  parameter logic [PC_W-1:0]    RESET_VEC = '0,
  parameter logic [PC_W-1:0]    PC_INC    = 1
) (
  input  logic        CLK,
  input  logic        RST,
  pc_seq_if.slave     bus
`ifdef PC_STATS_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] redirect_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STALL = 3'd2,
    FLUSH = 3'd3,
    HALT  = 3'd4
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            load;
  logic            redirect;
  logic            flush_q;
  logic            valid_q;

  // Next-state and next-PC selection; branch beats jump beats halt beats stall.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    load     = 1'b0;
    redirect = 1'b0;
    if (bus.run_en) begin
      case (state_q)
        IDLE: state_d = RUN;
        RUN, STALL, FLUSH: begin
          if (bus.br_taken) begin
            pc_d     = bus.br_target;
            state_d  = FLUSH;
            load     = 1'b1;
            redirect = 1'b1;
          end else if (bus.jmp) begin
            pc_d     = bus.jmp_target;
            state_d  = FLUSH;
            load     = 1'b1;
            redirect = 1'b1;
          end else if (bus.halt_req) begin
            state_d = HALT;
          end else if (bus.stall_req && state_q != FLUSH) begin
            // A stall seen in FLUSH came from the squashed instruction.
            state_d = STALL;
          end else begin
            pc_d    = pc_q + PC_INC;
            state_d = RUN;
            load    = 1'b1;
          end
        end
        HALT: if (bus.resume) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // State, PC and registered strobes; run_en low freezes everything but clears the flush pulse.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      pc_q    <= RESET_VEC;
      flush_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= redirect;
      valid_q <= (state_d == RUN) || (state_d == STALL) || (state_d == FLUSH);
    end
  end

`ifdef PC_STATS_EN
  // Saturating stall and redirect event counters.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      if (bus.run_en && state_q == STALL && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (redirect && redirect_cnt != 16'hFFFF)
        redirect_cnt <= redirect_cnt + 16'd1;
    end
  end
`endif

  assign bus.pc_out      = pc_q;
  assign bus.pc_en       = load;
  assign bus.if_flush    = flush_q;
  assign bus.fetch_valid = valid_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  pc_seq_if #(.PC_W(16)) bus ();

`ifdef PC_STATS_EN
  logic [15:0] stall_cnt;
  logic [15:0] redirect_cnt;
`endif

  pc_sequencer #(.PC_W(16), .RESET_VEC(16'h0000), .PC_INC(16'h0001)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
`ifdef PC_STATS_EN
    ,
    .stall_cnt(stall_cnt),
    .redirect_cnt(redirect_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_events();
    bus.stall_req  = 1'b0;
    bus.br_taken   = 1'b0;
    bus.jmp        = 1'b0;
    bus.halt_req   = 1'b0;
    bus.resume     = 1'b0;
  endtask

  task automatic expect_core(input string name, input logic [15:0] pc, input logic [2:0] st,
                             input logic fl, input logic fv);
    vecs++;
    if (bus.pc_out !== pc || bus.state !== st || bus.if_flush !== fl || bus.fetch_valid !== fv) begin
      errs++;
      $display("FAIL %s: got pc=%h state=%0d flush=%b valid=%b, want pc=%h state=%0d flush=%b valid=%b",
               name, bus.pc_out, bus.state, bus.if_flush, bus.fetch_valid, pc, st, fl, fv);
    end
  endtask

  task automatic test_reset();
    bus.run_en = 1'b0; bus.br_target = 16'h0; bus.jmp_target = 16'h0;
    clear_events();
    RST = 1'b0;
    #12;
    expect_core("reset_state", 16'h0000, 3'd0, 1'b0, 1'b0);
    vecs++;
    if (bus.pc_en !== 1'b0) begin errs++; $display("FAIL reset_pc_en: got %b want 0", bus.pc_en); end
    @(negedge CLK); RST = 1'b1;
    bus.run_en = 1'b1;
    #1;
    vecs++;
    if (bus.pc_en !== 1'b0) begin errs++; $display("FAIL idle_pc_en: got %b want 0", bus.pc_en); end
  endtask

  task automatic test_sequential();
    step();
    expect_core("idle_to_run", 16'h0000, 3'd1, 1'b0, 1'b1);
    vecs++;
    if (bus.pc_en !== 1'b1) begin errs++; $display("FAIL run_pc_en: got %b want 1", bus.pc_en); end
    for (int i = 1; i <= 4; i++) begin
      step();
      expect_core($sformatf("seq_%0d", i), 16'(i), 3'd1, 1'b0, 1'b1);
    end
  endtask

  task automatic test_stall();
    bus.stall_req = 1'b1;
    #1;
    vecs++;
    if (bus.pc_en !== 1'b0) begin errs++; $display("FAIL stall_pc_en: got %b want 0", bus.pc_en); end
    for (int i = 0; i < 3; i++) begin
      step();
      expect_core($sformatf("stall_%0d", i), 16'h0004, 3'd2, 1'b0, 1'b1);
    end
    bus.stall_req = 1'b0;
    step();
    expect_core("stall_release", 16'h0005, 3'd1, 1'b0, 1'b1);
    step();
    expect_core("to_six", 16'h0006, 3'd1, 1'b0, 1'b1);
  endtask

  task automatic test_branch_priority();
    bus.br_taken = 1'b1; bus.jmp = 1'b1;
    bus.br_target = 16'h0040; bus.jmp_target = 16'h0080;
    step();
    clear_events();
    expect_core("br_beats_jmp", 16'h0040, 3'd3, 1'b1, 1'b1);
  endtask

  task automatic test_flush_ignores_stall();
    bus.stall_req = 1'b1;
    step();
    clear_events();
    expect_core("flush_stall_ignored", 16'h0041, 3'd1, 1'b0, 1'b1);
  endtask

  task automatic test_halt();
    bus.jmp = 1'b1; bus.jmp_target = 16'h0010;
    step();
    clear_events();
    expect_core("jmp_to_10", 16'h0010, 3'd3, 1'b1, 1'b1);
    bus.halt_req = 1'b1;
    step();
    clear_events();
    expect_core("halt_enter", 16'h0010, 3'd4, 1'b0, 1'b0);
    bus.br_taken = 1'b1; bus.br_target = 16'h0300; bus.stall_req = 1'b1;
    #1;
    vecs++;
    if (bus.pc_en !== 1'b0) begin errs++; $display("FAIL halt_pc_en: got %b want 0", bus.pc_en); end
    step();
    clear_events();
    expect_core("halt_ignores_br", 16'h0010, 3'd4, 1'b0, 1'b0);
    bus.resume = 1'b1;
    step();
    clear_events();
    expect_core("halt_resume", 16'h0010, 3'd1, 1'b0, 1'b1);
    step();
    expect_core("after_resume", 16'h0011, 3'd1, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    bus.br_taken = 1'b1; bus.br_target = 16'h0100;
    step();
    clear_events();
    expect_core("b2b_first", 16'h0100, 3'd3, 1'b1, 1'b1);
    bus.jmp = 1'b1; bus.jmp_target = 16'h0200;
    step();
    clear_events();
    expect_core("b2b_second", 16'h0200, 3'd3, 1'b1, 1'b1);
    bus.run_en = 1'b0; bus.br_taken = 1'b1; bus.br_target = 16'h0500;
    #1;
    vecs++;
    if (bus.pc_en !== 1'b0) begin errs++; $display("FAIL gate_pc_en: got %b want 0", bus.pc_en); end
    step();
    clear_events();
    expect_core("run_gate_freeze", 16'h0200, 3'd3, 1'b0, 1'b1);
    bus.run_en = 1'b1;
    step();
    expect_core("run_gate_release", 16'h0201, 3'd1, 1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    bus.jmp = 1'b1; bus.jmp_target = 16'hFFFF;
    step();
    clear_events();
    expect_core("wrap_load", 16'hFFFF, 3'd3, 1'b1, 1'b1);
    step();
    expect_core("wrap_zero", 16'h0000, 3'd1, 1'b0, 1'b1);
    step();
    expect_core("wrap_one", 16'h0001, 3'd1, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
`ifdef PC_STATS_EN
    vecs++;
    if (redirect_cnt !== 16'd5 || stall_cnt !== 16'd3) begin
      errs++;
      $display("FAIL stats_before_reset: got redirect=%0d stall=%0d want redirect=5 stall=3",
               redirect_cnt, stall_cnt);
    end
`endif
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    expect_core("async_reset", 16'h0000, 3'd0, 1'b0, 1'b0);
`ifdef PC_STATS_EN
    vecs++;
    if (redirect_cnt !== 16'd0 || stall_cnt !== 16'd0) begin
      errs++;
      $display("FAIL stats_after_reset: got redirect=%0d stall=%0d want 0 0", redirect_cnt, stall_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_priority();
    test_flush_ignores_stall();
    test_halt();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
